// File: rtl/chi_squared_engine.sv
// chi_squared_engine
//   Walks the expected (E) and observed (O) histograms held in a dual-port
//   synchronous ROM. It accumulates the Pearson chi-squared statistic,
//   sum over bins of (O-E)^2/E, as unsigned fixed point with FRAC_BITS
//   fractional bits. Every term and the running sum saturate at 0xFFFF_FFFF.
//   When a run finishes, the result is presented with a one-cycle valid pulse.
//
// Ports
//   clk        system clock, rising edge
//   rst        asynchronous reset, active low
//   E_in       expected count from memory port A (1-cycle registered read)
//   O_in       observed count from memory port B (1-cycle registered read)
//   data_rdy   start request; a run starts on its rising edge, sampled in IDLE only
//   addra_out  read address for port A (registered)
//   addrb_out  read address for port B, always equal to addra_out
//   chi_out    last completed result, held until the next run completes
//   data_vld   one-cycle pulse when chi_out is updated
//
// state | meaning
// ------+-----------------------------------------------------------
// IDLE  | waiting for a rising edge on data_rdy
// FETCH | present the address of the current bin
// WAIT  | memory read in flight
// CAP   | latch E/O, form |O-E|^2; E==0 skips the divider
// DIV   | restoring divide of (sq << FRAC_BITS) / E, one bit per cycle
// ACC   | saturating add of the term; next bin or finish
// DONE  | publish the accumulated sum and pulse data_vld

module chi_squared_engine #(
   parameter int N_BINS    = 256,
   parameter int ADDR_W    = 8,
   parameter int DATA_W    = 16,
   parameter int FRAC_BITS = 8
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [DATA_W-1:0] E_in,
   input  logic [DATA_W-1:0] O_in,
   input  logic              data_rdy,
   output logic [ADDR_W-1:0] addra_out,
   output logic [ADDR_W-1:0] addrb_out,
   output logic [31:0]       chi_out,
   output logic              data_vld
);

   localparam int SQ_W  = 2 * DATA_W;
   localparam int DVD_W = SQ_W + FRAC_BITS;
   localparam int CNT_W = $clog2(DVD_W);

   typedef enum logic [2:0] {
      IDLE,
      FETCH,
      WAIT,
      CAP,
      DIV,
      ACC,
      DONE
   } state_t;

   state_t state, state_nxt;

   logic              data_rdy_q;
   logic [ADDR_W-1:0] bin_idx;
   logic [ADDR_W-1:0] addr_q;
   logic [DATA_W-1:0] e_q;
   logic [DVD_W-1:0]  dvd;
   logic [DATA_W-1:0] rem;
   logic [DVD_W-1:0]  quo;
   logic [CNT_W-1:0]  div_cnt;
   logic [31:0]       acc;
   logic [31:0]       chi_q;
   logic              vld_q;

   logic              start;
   logic              last_bin;
   logic              div_tc;
   logic [DATA_W-1:0] diff;
   logic [SQ_W-1:0]   sq;
   logic [DATA_W:0]   trial;
   logic              trial_ge;
   logic [DATA_W-1:0] rem_nxt;
   logic              quo_ovf;
   logic [31:0]       term;
   logic [32:0]       sum;
   logic [31:0]       acc_nxt;

   assign start    = data_rdy & ~data_rdy_q;
   assign last_bin = (bin_idx == ADDR_W'(N_BINS - 1));
   assign div_tc   = (div_cnt == '0);

   assign diff = (O_in >= E_in) ? (O_in - E_in) : (E_in - O_in);
   assign sq   = SQ_W'(diff) * SQ_W'(diff);

   // Restoring step: bring the next dividend bit into the partial remainder.
   // The remainder is always below E, so it fits back into DATA_W bits.
   assign trial    = {rem, dvd[DVD_W-1]};
   assign trial_ge = (trial >= {1'b0, e_q});
   assign rem_nxt  = trial_ge ? DATA_W'(trial - {1'b0, e_q}) : DATA_W'(trial);

   // The quotient can grow to DVD_W bits; anything above bit 31 clamps the term.
   assign quo_ovf = ((quo >> 32) != '0);
   assign term    = quo_ovf ? 32'hFFFF_FFFF : quo[31:0];
   assign sum     = {1'b0, acc} + {1'b0, term};
   assign acc_nxt = sum[32] ? 32'hFFFF_FFFF : sum[31:0];

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (start) state_nxt = FETCH;
         FETCH:   state_nxt = WAIT;
         WAIT:    state_nxt = CAP;
         CAP:     state_nxt = (E_in == '0) ? ACC : DIV;
         DIV:     if (div_tc) state_nxt = ACC;
         ACC:     state_nxt = last_bin ? DONE : FETCH;
         DONE:    state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         data_rdy_q <= 1'b0;
         bin_idx    <= '0;
         addr_q     <= '0;
         e_q        <= '0;
         dvd        <= '0;
         rem        <= '0;
         quo        <= '0;
         div_cnt    <= '0;
         acc        <= '0;
         chi_q      <= '0;
         vld_q      <= 1'b0;
      end else begin
         data_rdy_q <= data_rdy;
         vld_q      <= 1'b0;
         case (state)
            IDLE: begin
               if (start) begin
                  acc     <= '0;
                  bin_idx <= '0;
               end
            end
            FETCH: begin
               addr_q <= bin_idx;
            end
            CAP: begin
               // quo is cleared here so an E==0 bin contributes a zero term.
               e_q     <= E_in;
               dvd     <= {sq, {FRAC_BITS{1'b0}}};
               rem     <= '0;
               quo     <= '0;
               div_cnt <= CNT_W'(DVD_W - 1);
            end
            DIV: begin
               dvd     <= dvd << 1;
               rem     <= rem_nxt;
               quo     <= {quo[DVD_W-2:0], trial_ge};
               div_cnt <= div_cnt - CNT_W'(1);
            end
            ACC: begin
               acc <= acc_nxt;
               if (!last_bin) begin
                  bin_idx <= bin_idx + ADDR_W'(1);
               end
            end
            DONE: begin
               chi_q <= acc;
               vld_q <= 1'b1;
            end
            default: ;
         endcase
      end
   end

   assign addra_out = addr_q;
   assign addrb_out = addr_q;
   assign chi_out   = chi_q;
   assign data_vld  = vld_q;

endmodule

// File: tb/tb_chi_squared_engine.sv
// tb_chi_squared_engine
//   Bench for chi_squared_engine. A behavioural dual-port ROM feeds the
//   engine. Expected results are queued when each run is launched, and a
//   monitor pops and compares them whenever data_vld pulses.

module tb_chi_squared_engine;

   logic        clk;
   logic        rst;
   logic [15:0] E_in;
   logic [15:0] O_in;
   logic        data_rdy;
   logic [7:0]  addra_out;
   logic [7:0]  addrb_out;
   logic [31:0] chi_out;
   logic        data_vld;

   logic [15:0] e_mem [256];
   logic [15:0] o_mem [256];

   logic [31:0] exp_q [$];
   int          n_tests;
   int          n_fail;
   int          vld_cnt;

   chi_squared_engine dut (
      .clk       (clk),
      .rst       (rst),
      .E_in      (E_in),
      .O_in      (O_in),
      .data_rdy  (data_rdy),
      .addra_out (addra_out),
      .addrb_out (addrb_out),
      .chi_out   (chi_out),
      .data_vld  (data_vld)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk) begin
      E_in <= e_mem[addra_out];
      O_in <= o_mem[addrb_out];
   end

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_tests++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   always @(negedge clk) begin
      if (data_vld) begin
         vld_cnt++;
         if (exp_q.size() == 0) begin
            chk("spurious_vld", 64'd1, 64'd0);
         end else begin
            chk("chi_out", 64'(chi_out), 64'(exp_q.pop_front()));
         end
      end
   end

   task automatic fill(input logic [15:0] e, input logic [15:0] o);
      for (int i = 0; i < 256; i++) begin
         e_mem[i] = e;
         o_mem[i] = o;
      end
   endtask

   function automatic logic [31:0] model_chi();
      logic [63:0] sum, t, d, eo, oo;
      sum = 0;
      for (int i = 0; i < 256; i++) begin
         eo = 64'(e_mem[i]);
         oo = 64'(o_mem[i]);
         if (eo != 0) begin
            d = (oo >= eo) ? (oo - eo) : (eo - oo);
            t = ((d * d) << 8) / eo;
            if (t > 64'hFFFF_FFFF) t = 64'hFFFF_FFFF;
            sum = sum + t;
            if (sum > 64'hFFFF_FFFF) sum = 64'hFFFF_FFFF;
         end
      end
      return sum[31:0];
   endfunction

   function automatic int model_lat();
      int lat;
      lat = 1;
      for (int i = 0; i < 256; i++) begin
         lat += (e_mem[i] != 0) ? 44 : 4;
      end
      return lat;
   endfunction

   // Latency is counted in clock edges from the edge that detects start.
   task automatic run_case(input string tag, input logic [31:0] exp_chi);
      int lat, exp_lat, base;
      exp_lat = model_lat();
      base    = vld_cnt;
      exp_q.push_back(exp_chi);
      @(negedge clk);
      data_rdy = 1'b1;
      @(posedge clk);
      #1 data_rdy = 1'b0;
      lat = 0;
      while (!data_vld && lat < 20000) begin
         @(posedge clk);
         #1 lat++;
      end
      if (!data_vld) begin
         chk({tag, "_timeout"}, 64'd0, 64'd1);
         exp_q.delete();
      end else begin
         chk({tag, "_latency"}, 64'(lat), 64'(exp_lat));
         @(posedge clk);
         #1 chk({tag, "_vld_pulse"}, 64'(data_vld), 64'd0);
         chk({tag, "_vld_count"}, 64'(vld_cnt - base), 64'd1);
      end
   endtask

   initial begin
      int base;
      n_tests  = 0;
      n_fail   = 0;
      vld_cnt  = 0;
      rst      = 1'b0;
      data_rdy = 1'b0;
      fill(16'd0, 16'd0);
      repeat (3) @(negedge clk);
      chk("rst_addra", 64'(addra_out), 64'd0);
      chk("rst_addrb", 64'(addrb_out), 64'd0);
      chk("rst_chi", 64'(chi_out), 64'd0);
      chk("rst_vld", 64'(data_vld), 64'd0);
      rst = 1'b1;
      repeat (2) @(negedge clk);

      fill(16'd100, 16'd100);
      run_case("all_equal", 32'h0000_0000);

      fill(16'd0, 16'd0);
      e_mem[5] = 16'd100; o_mem[5] = 16'd110;
      run_case("bin5_over", 32'h0000_0100);
      e_mem[5] = 16'd110; o_mem[5] = 16'd100;
      run_case("bin5_under", 32'h0000_00E8);

      fill(16'd0, 16'd0);
      e_mem[0] = 16'd3; o_mem[0] = 16'd4;
      run_case("bin0_trunc", 32'h0000_0055);
      fill(16'd0, 16'd0);
      e_mem[255] = 16'd3; o_mem[255] = 16'd4;
      run_case("bin255_trunc", 32'h0000_0055);
      chk("addr_hold", 64'(addra_out), 64'd255);

      fill(16'd0, 16'd0);
      for (int k = 0; k < 12; k++) begin
         int b;
         b = $urandom_range(0, 255);
         e_mem[b] = 16'($urandom_range(1, 2000));
         o_mem[b] = 16'($urandom_range(0, 3000));
      end
      run_case("random", model_chi());

      // Abort during the divide of bin 10; earlier bins have E==0 (4 cycles each).
      fill(16'd0, 16'd0);
      e_mem[10] = 16'd200; o_mem[10] = 16'd1000;
      base = vld_cnt;
      @(negedge clk);
      data_rdy = 1'b1;
      @(posedge clk);
      #1 data_rdy = 1'b0;
      repeat (63) @(posedge clk);
      #2 rst = 1'b0;
      #1;
      chk("abort_addra", 64'(addra_out), 64'd0);
      chk("abort_addrb", 64'(addrb_out), 64'd0);
      chk("abort_chi", 64'(chi_out), 64'd0);
      chk("abort_vld", 64'(data_vld), 64'd0);
      repeat (5) @(negedge clk);
      rst = 1'b1;
      repeat (20) @(negedge clk);
      chk("abort_no_vld", 64'(vld_cnt - base), 64'd0);
      run_case("after_abort", 32'h000C_8000);

      fill(16'd1, 16'd65535);
      run_case("saturate", 32'hFFFF_FFFF);

      fill(16'd100, 16'd100);
      e_mem[7] = 16'd0; o_mem[7] = 16'd50;
      run_case("e_zero_skip", 32'h0000_0000);

      fill(16'd0, 16'd0);
      e_mem[0] = 16'd3; o_mem[0] = 16'd4;
      exp_q.push_back(32'h0000_0055);
      base = vld_cnt;
      @(negedge clk);
      data_rdy = 1'b1;
      repeat (30000) @(negedge clk);
      data_rdy = 1'b0;
      repeat (5) @(negedge clk);
      chk("hold_high_pulses", 64'(vld_cnt - base), 64'd1);
      chk("queue_drained", 64'(exp_q.size()), 64'd0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
